ab_stimulus_gen: RTL and testbench

- Sequential stimulus source that drives the 1-bit a/b signal pair into the downstream reg/wire demonstration stage.
- On a start pulse it emits a fixed-length sequence of {a,b} vectors over a valid/ready handshake.
- It tags each vector with its index and pulses done after the last vector is accepted.
- Replaces hard-coded continuous assigns on a/b with clocked, repeatable stimulus.

---
 rtl/ab_stimulus_gen.sv | 127 ++++++++++++
 tb/tb_ab_stimulus_gen.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/ab_stimulus_gen.sv
// Clocked a/b stimulus source: emits NUM_VEC {a,b} vectors over valid/ready per start pulse.
// Optional LFSR pattern for mode 2 is built only when AB_GEN_LFSR_EN is defined.
module ab_stimulus_gen #(
    parameter int         NUM_VEC = 8,
    parameter logic [3:0] SEED    = 4'hA
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [1:0] mode,
    input  logic       out_ready,
    output logic       out_valid,
    output logic       a,
    output logic       b,
    output logic [7:0] vec_idx,
    output logic       busy,
    output logic       done
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;
    localparam logic [7:0] LAST   = 8'(NUM_VEC - 1);

    logic [1:0] r_state;
    logic [1:0] r_mode;
    logic [7:0] r_idx;
    logic       r_valid;
    logic       r_a;
    logic       r_b;
    logic       r_busy;
    logic       r_done;

    logic       w_xfer;
    logic [7:0] w_idx_nxt;
    logic [1:0] w_rnd_first;
    logic [1:0] w_rnd_step;

    // rnd carries the mode-2 bits for the vector about to be presented
    function automatic logic [1:0] f_vec(input logic [1:0] m, input logic [1:0] idx,
                                         input logic [1:0] rnd);
        case (m)
            2'd1:    f_vec = idx[0] ? 2'b01 : 2'b10;
            2'd2:    f_vec = rnd;
            2'd3:    f_vec = 2'b11;
            default: f_vec = idx;
        endcase
    endfunction

    assign w_xfer    = r_valid && out_ready;
    assign w_idx_nxt = r_idx + 8'd1;

`ifdef AB_GEN_LFSR_EN
    logic [3:0] r_lfsr;
    logic [3:0] w_lfsr_nxt;

    assign w_lfsr_nxt  = {r_lfsr[2:0], r_lfsr[3] ^ r_lfsr[2]};
    assign w_rnd_first = SEED[1:0];
    assign w_rnd_step  = w_lfsr_nxt[1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_lfsr <= SEED;
        end else if (r_state == S_IDLE && start) begin
            r_lfsr <= SEED;
        end else if (r_state == S_RUN && w_xfer) begin
            r_lfsr <= w_lfsr_nxt;
        end
    end
`else
    assign w_rnd_first = 2'b00;
    assign w_rnd_step  = w_idx_nxt[1:0];
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_mode  <= 2'd0;
            r_idx   <= 8'd0;
            r_valid <= 1'b0;
            r_a     <= 1'b0;
            r_b     <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_state    <= S_RUN;
                        r_mode     <= mode;
                        r_idx      <= 8'd0;
                        r_valid    <= 1'b1;
                        r_busy     <= 1'b1;
                        {r_a, r_b} <= f_vec(mode, 2'b00, w_rnd_first);
                    end
                end
                S_RUN: begin
                    if (w_xfer) begin
                        if (r_idx == LAST) begin
                            r_state <= S_DONE;
                            r_valid <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_idx      <= w_idx_nxt;
                            {r_a, r_b} <= f_vec(r_mode, w_idx_nxt[1:0], w_rnd_step);
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign out_valid = r_valid;
    assign a         = r_a;
    assign b         = r_b;
    assign vec_idx   = r_idx;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule

// File: tb/tb_ab_stimulus_gen.sv
// Directed bench for ab_stimulus_gen: scoreboard of expected {a,b,idx} checked on each transfer.
module tb_ab_stimulus_gen;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [1:0] mode = 2'd0;
    logic       out_ready = 1'b1;
    logic       out_valid, a, b, busy, done;
    logic [7:0] vec_idx;
    logic       v1, a1, b1, busy1, done1;
    logic [7:0] idx1;

    int checks = 0;
    int errors = 0;
    int ndone  = 0;
    logic [9:0] sb[$];

    always #5 clk = ~clk;

    ab_stimulus_gen #(.NUM_VEC(8), .SEED(4'hA)) dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .out_ready(out_ready),
        .out_valid(out_valid), .a(a), .b(b), .vec_idx(vec_idx), .busy(busy), .done(done));

    ab_stimulus_gen #(.NUM_VEC(1), .SEED(4'hA)) dut1 (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .out_ready(out_ready),
        .out_valid(v1), .a(a1), .b(b1), .vec_idx(idx1), .busy(busy1), .done(done1));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected vectors for a whole run, derived from the pattern definitions.
    task automatic push_run(input logic [1:0] m, input int n);
        logic [3:0] lf;
        logic [1:0] ab;
        lf = 4'hA;
        for (int i = 0; i < n; i++) begin
            case (m)
                2'd0: ab = 2'(i % 4);
                2'd1: ab = (i % 2 == 0) ? 2'b10 : 2'b01;
`ifdef AB_GEN_LFSR_EN
                2'd2: ab = lf[1:0];
`else
                2'd2: ab = 2'(i % 4);
`endif
                default: ab = 2'b11;
            endcase
            sb.push_back({ab, 8'(i)});
            lf = {lf[2:0], lf[3] ^ lf[2]};
        end
    endtask

    // Inputs change and outputs are sampled at negedge; a transfer happens at the next posedge.
    task automatic tick();
        logic [9:0] e;
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) chk("sb_unexpected_xfer", {22'd0, a, b, vec_idx}, 32'h3ff);
            else begin
                e = sb.pop_front();
                chk("sb_vector", {22'd0, a, b, vec_idx}, {22'd0, e});
            end
        end
        if (done) ndone++;
        @(negedge clk);
    endtask

    task automatic start_run(input logic [1:0] m);
        push_run(m, 8);
        mode = m; start = 1'b1;
        tick();
        start = 1'b0;
        chk("start_valid_busy_idx", {out_valid, busy, vec_idx}, {1'b1, 1'b1, 8'd0});
    endtask

    task automatic run_until_done(output int cyc);
        cyc = 0;
        while (!done && cyc < 50) begin tick(); cyc++; end
        chk("done_within_bound", {31'd0, done}, 32'd1);
        chk("done_out_valid_low", {30'd0, out_valid, busy}, 32'b01);
        tick();
        chk("after_done_idle", {30'd0, done, busy}, 32'd0);
        chk("sb_empty", sb.size(), 0);
    endtask

    initial begin
        int c;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("reset_idle", {20'd0, out_valid, a, b, vec_idx, busy, done}, 32'd0);
        end

        // count mode, free-flowing; dut1 (single vector) shares the stimulus
        ndone = 0;
        start_run(2'd0);
        chk("nv1_first", {20'd0, v1, a1, b1, idx1, busy1, done1}, {20'd0, 1'b1, 2'b00, 8'd0, 1'b1, 1'b0});
        tick();
        chk("nv1_done", {29'd0, v1, busy1, done1}, 32'b011);
        run_until_done(c);
        chk("count_no_bubbles", c + 1, 8);
        chk("count_one_done", ndone, 1);

        // backpressure in alternate mode
        start_run(2'd1);
        tick(); tick();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_hold", {21'd0, out_valid, a, b, vec_idx}, {21'd0, 1'b1, 2'b10, 8'd2});
        end
        out_ready = 1'b1;
        run_until_done(c);

        // mode 2: LFSR when enabled, count otherwise
        start_run(2'd2);
`ifdef AB_GEN_LFSR_EN
        chk("lfsr_first", {30'd0, a, b}, 32'b10);
`else
        chk("mode2_count_first", {30'd0, a, b}, 32'b00);
`endif
        run_until_done(c);

        // start/mode ignored mid-run
        ndone = 0;
        start_run(2'd3);
        repeat (4) tick();
        chk("mid_idx4", vec_idx, 8'd4);
        start = 1'b1; mode = 2'd0;
        tick();
        start = 1'b0;
        run_until_done(c);
        repeat (3) tick();
        chk("ignore_one_done", ndone, 1);

        // reset mid-run
        ndone = 0;
        start_run(2'd0);
        repeat (5) tick();
        chk("pre_rst_idx5", vec_idx, 8'd5);
        rst = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        chk("mid_rst", {22'd0, out_valid, vec_idx, busy}, 32'd0);
        rst = 1'b0;
        sb.delete();
        tick();
        chk("mid_rst_no_done", {31'd0, done}, 32'd0);
        start_run(2'd1);
        run_until_done(c);
        chk("rst_run_one_done", ndone, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule
